serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
- Receive-side counterpart to the team's serial frame transmitter in the rsz hierarchical test designs.
- Recovers framed, LSB-first serial words from a single-bit line: 1 start bit (0), DATA_WIDTH data bits, 1 stop bit (1); idle line is 1.
- Presents each recovered word on a valid/ready output port.
- Used as a small sequential leaf inside hierarchical test tops, so resizer buffer removal and repair run across real register boundaries.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 1..16.
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal range 2..256. H = CLKS_PER_BIT/2 (integer division).

Ports:
- clk  input  1  single clock; all flops rising-edge.
- rst  input  1  synchronous, active-high reset.
- rxd  input  1  serial line, idle high.
- data_out  output  DATA_WIDTH  last received word; LSB = first data bit.
- valid  output  1  data_out holds an unconsumed word.
- ready  input  1  consumer accepts data_out when valid & ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: word completed while a prior word was unconsumed.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, counters=0, shift reg=0, sync flops=1, data_out=0, valid=0, frame_err=0, overrun=0, busy=0.
- Reset mid-frame aborts the frame with no valid, frame_err or overrun.
- Synchroniser: rxd passes through 2 flops to give rxd_s; the FSM uses only rxd_s.
- IDLE:
  - rxd_s==0 in cycle c0 -> START; bit counter cleared.
- START:
  - Sample at c0+H.
  - rxd_s==0 -> DATA, bit index=0.
  - rxd_s==1 (glitch) -> IDLE; no outputs change.
- DATA:
  - Sample at c0+H+k*CLKS_PER_BIT, k=1..DATA_WIDTH.
  - Each sample shifts in so the first bit ends at bit 0.
  - After bit DATA_WIDTH -> STOP.
- STOP:
  - Sample at c0+H+(DATA_WIDTH+1)*CLKS_PER_BIT.
  - rxd_s==1: complete word -> IDLE.
  - rxd_s==0: frame_err=1 for the next cycle only, word discarded -> BREAK.
- BREAK:
  - Wait for rxd_s==1, then -> IDLE.
  - A held-low line never produces a second frame_err or a false start.
- Word completion (registered, visible the cycle after the stop sample, i.e. c0+H+(DATA_WIDTH+1)*CLKS_PER_BIT+1):
  - valid==0: data_out<=word, valid<=1.
  - valid==1 and ready==1 in the completion cycle: data_out<=new word, valid stays 1, no overrun.
  - valid==1 and ready==0: data_out and valid unchanged, new word dropped, overrun=1 for one cycle.
- Handshake:
  - Transfer happens when valid & ready at a clk edge.
  - With no new completion, valid clears next cycle and data_out holds its value.
  - data_out stable whenever valid==1.
  - ready is ignored when valid==0.
- Back-to-back frames: FSM is back in IDLE the cycle after the stop sample, so a start bit immediately following the stop bit (>=H cycles of stop level) is received.
- busy = (state != IDLE), registered with the state.
- Sampling uses one down- or up-counter of width clog2(CLKS_PER_BIT)+1 and a bit index of width clog2(DATA_WIDTH+1); neither wraps within a frame.

Test Plan:
- DATA_WIDTH=8, CLKS_PER_BIT=4, ready=1; rst 3 cycles, then frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first) -> data_out=0xA5, valid high exactly c0+39 for 1 cycle; frame_err=0, overrun=0.
- ready=0; frames 0x3C then 0xC3 back-to-back -> data_out=0x3C, valid=1, overrun pulses once at the second completion; raise ready -> valid falls next cycle, data_out stays 0x3C.
- Stop bit driven 0 on frame 0xFF, line held low 20 cycles, then high -> exactly one frame_err pulse; valid stays 0; no new frame until rxd returns high and falls again.
- rxd low pulse of 1 cycle while IDLE -> START entered, rxd_s==1 at mid-sample, back to IDLE; no valid, no frame_err.
- Assert rst at data bit 4 of frame 0x55, release, send 0x12 -> only 0x12 is delivered; no stray valid, frame_err or overrun.
- ready=1 held; word completes in the same cycle as a pending transfer (set up with 0x01 then 0x02 arriving while valid=1 and ready asserted at completion) -> valid stays 1, data_out=0x02, overrun=0.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, stop bit.
// Recovered words are presented on a valid/ready port.
module serial_frame_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] msb_in;
    logic                  sync1;
    logic                  rxd_s;

    always_comb begin
        msb_in = '0;
        msb_in[DATA_WIDTH-1] = rxd_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            sync1     <= 1'b1;
            rxd_s     <= 1'b1;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync1     <= rxd;
            rxd_s     <= sync1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready)
                valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state   <= START;
                        busy    <= 1'b1;
                        cnt     <= HALF_M1;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= DATA;
                        cnt     <= FULL_M1;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shift_reg <= (shift_reg >> 1) | msb_in;
                        cnt       <= FULL_M1;
                        if (bit_idx == LAST_BIT)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + BW'(1);
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        // Same-edge hand-off replaces the word being consumed
                        if (!valid || ready) begin
                            data_out <= shift_reg;
                            valid    <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        frame_err <= 1'b1;
                        state     <= BRK;
                    end
                end
                BRK: begin
                    if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
